sound_request_arbiter: RTL and testbench

- Parametrised successor to the combinational sound-request mux.
- Latches one-cycle sound events from game logic (key presses, hole/border/ball collisions) into sticky pending bits.
- Arbitrates them by fixed priority and drives one tone at a time to the audio tone generator for a programmable duration, followed by a silent gap.
- Optional pre-emption by higher-priority events.

---
 rtl/sound_pkg.sv | 21 ++
 rtl/prio_encoder.sv | 20 ++
 rtl/sound_request_arbiter.sv | 102 ++++++++++
 tb/tb_sound_request_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared types and constants for the sound request arbiter
package sound_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  // Board source map; index 0 is the highest priority
  localparam int SRC_KEY_ENTER = 0;
  localparam int SRC_HOLE      = 1;
  localparam int SRC_BALL      = 2;
  localparam int SRC_BORDER    = 3;
  localparam int SRC_KEY_X     = 4;
  localparam int SRC_KEY_Y     = 5;

  // Defaults: 250 ms tone, 50 ms gap at 50 MHz
  localparam int DEF_NUM_SRC     = 6;
  localparam int DEF_PLAY_CYCLES = 12_500_000;
  localparam int DEF_GAP_CYCLES  = 2_500_000;
  localparam int DEF_PREEMPT     = 1;
  localparam int DEF_CNT_W       = 24;

endpackage

// File: rtl/prio_encoder.sv
// rtl/prio_encoder.sv - lowest-index-wins priority encoder
module prio_encoder #(
  parameter int N    = 6,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    vec,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    valid = |vec;
    idx   = '0;
    // Scan downward so the lowest set index is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/sound_request_arbiter.sv
// rtl/sound_request_arbiter.sv - latches sound events and plays them one at a time
// by fixed priority, with a timed tone, optional silent gap and optional pre-emption.
module sound_request_arbiter
  import sound_pkg::*;
#(
  parameter int NUM_SRC     = DEF_NUM_SRC,
  parameter int PLAY_CYCLES = DEF_PLAY_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int PREEMPT     = DEF_PREEMPT,
  parameter int CNT_W       = DEF_CNT_W,
  localparam int ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [NUM_SRC-1:0] event_i,
  input  logic               mute_i,
  output logic               sound_on,
  output logic [ID_W-1:0]    tone_id,
  output logic               tone_start,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               busy
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_SRC-1:0] pending, grant_clear;
  logic [ID_W-1:0]    winner, tone_id_nxt;
  logic               win_valid, grant;

  prio_encoder #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_prio (
    .vec   (pending),
    .valid (win_valid),
    .idx   (winner)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tone_id_nxt = tone_id;
    grant       = 1'b0;
    if (mute_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) grant = 1'b1;
        end
        PLAY: begin
          // A pre-empting grant also wins over the natural end of the tone
          if (PREEMPT != 0 && win_valid && winner < tone_id) begin
            grant = 1'b1;
          end else if (cnt == '0) begin
            if (GAP_CYCLES == 0) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = GAP;
              cnt_nxt   = CNT_W'(GAP_CYCLES - 1);
            end
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state_nxt = IDLE;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (grant) begin
      state_nxt   = PLAY;
      cnt_nxt     = CNT_W'(PLAY_CYCLES - 1);
      tone_id_nxt = winner;
    end
  end

  assign grant_clear = grant ? (NUM_SRC'(1) << winner) : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= '0;
      tone_id    <= '0;
      tone_start <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      tone_id    <= tone_id_nxt;
      tone_start <= grant;
      pending    <= mute_i ? '0 : ((pending | event_i) & ~grant_clear);
    end
  end

  assign sound_on  = (state == PLAY);
  assign busy      = (state != IDLE);
  assign pending_o = pending;

endmodule

// File: tb/tb_sound_request_arbiter.sv
// tb/tb_sound_request_arbiter.sv - randomized and directed checks of two arbiter
// instances (pre-emption on / off) against a cycle-level behavioural model.
module tb_sound_request_arbiter;
  import sound_pkg::*;

  localparam int NS = 6;
  localparam int PC = 4;
  localparam int GC = 2;
  localparam int CW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          mute = 1'b0;
  logic [NS-1:0] ev = '0;
  logic [1:0]    son, tst, bsy;
  logic [IW-1:0] tid [2];
  logic [NS-1:0] pnd [2];

  sound_request_arbiter #(
    .NUM_SRC(NS), .PLAY_CYCLES(PC), .GAP_CYCLES(GC), .PREEMPT(1), .CNT_W(CW)
  ) dut_pre (
    .clk(clk), .resetN(resetN), .event_i(ev), .mute_i(mute),
    .sound_on(son[0]), .tone_id(tid[0]), .tone_start(tst[0]),
    .pending_o(pnd[0]), .busy(bsy[0])
  );

  sound_request_arbiter #(
    .NUM_SRC(NS), .PLAY_CYCLES(PC), .GAP_CYCLES(GC), .PREEMPT(0), .CNT_W(CW)
  ) dut_nopre (
    .clk(clk), .resetN(resetN), .event_i(ev), .mute_i(mute),
    .sound_on(son[1]), .tone_id(tid[1]), .tone_start(tst[1]),
    .pending_o(pnd[1]), .busy(bsy[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Model: remaining tone cycles, remaining gap cycles, current id, pending set
  int            m_left [2];
  int            m_gap  [2];
  int            m_id   [2];
  logic [NS-1:0] m_pend [2];
  bit            m_start[2];
  bit            m_pre  [2] = '{1'b1, 1'b0};

  int            cyc = 0;
  int            start_cyc[2];
  int            son_cnt[2];
  int            q0[$];
  int            q1[$];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_gap[k] = 0; m_id[k] = 0; m_pend[k] = '0; m_start[k] = 1'b0;
    end
  endfunction

  function automatic void model_step(int k, logic [NS-1:0] e, logic m);
    int win;
    bit grant;
    m_start[k] = 1'b0;
    if (m) begin
      m_pend[k] = '0; m_left[k] = 0; m_gap[k] = 0;
      return;
    end
    win = -1;
    for (int i = NS - 1; i >= 0; i--) if (m_pend[k][i]) win = i;
    grant = (win >= 0) &&
            ((m_left[k] == 0 && m_gap[k] == 0) ||
             (m_left[k] > 0 && m_pre[k] && win < m_id[k]));
    m_pend[k] = m_pend[k] | e;
    if (grant) begin
      m_pend[k][win] = 1'b0;
      m_id[k] = win; m_left[k] = PC; m_gap[k] = 0; m_start[k] = 1'b1;
    end else if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) m_gap[k] = GC;
    end else if (m_gap[k] > 0) begin
      m_gap[k]--;
    end
  endfunction

  task automatic compare(input int k);
    check($sformatf("sound_on[%0d]", k),   son[k], m_left[k] > 0);
    check($sformatf("tone_start[%0d]", k), tst[k], m_start[k]);
    check($sformatf("tone_id[%0d]", k),    tid[k], m_id[k]);
    check($sformatf("pending[%0d]", k),    pnd[k], m_pend[k]);
    check($sformatf("busy[%0d]", k),       bsy[k], (m_left[k] > 0) || (m_gap[k] > 0));
  endtask

  task automatic tick(input logic [NS-1:0] e, input logic m);
    ev = e; mute = m;
    @(posedge clk); #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      model_step(k, e, m);
      compare(k);
      if (son[k]) son_cnt[k]++;
      if (tst[k]) begin
        start_cyc[k] = cyc;
        if (k == 0) q0.push_back(int'(tid[k]));
        else        q1.push_back(int'(tid[k]));
      end
    end
    ev = '0; mute = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, 1'b0);
  endtask

  task automatic clear_log();
    q0.delete(); q1.delete();
    son_cnt[0] = 0; son_cnt[1] = 0;
  endtask

  task automatic check_seq(input string tag, input int k, input int exp[$]);
    int got[$];
    got = (k == 0) ? q0 : q1;
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_id%0d", tag, i), got[i], exp[i]);
  endtask

  int ev_cyc;

  initial begin
    model_reset();
    #12;
    for (int k = 0; k < 2; k++) compare(k);
    @(posedge clk); #1;
    resetN = 1'b1;
    idle(3);

    // Single event, latency and tone length
    clear_log();
    tick(NS'(1) << SRC_BORDER, 1'b0);
    ev_cyc = cyc - 1;
    idle(12);
    check("single_latency", start_cyc[0] - ev_cyc, 2);
    check("single_len", son_cnt[0], PC);
    check_seq("single", 0, '{3});

    // Simultaneous events served in priority order
    clear_log();
    tick(6'b100101, 1'b0);
    idle(30);
    check_seq("simul", 0, '{0, 2, 5});
    check("simul_len", son_cnt[0], 3 * PC);

    // Pre-emption while id 4 is playing at counter 2
    clear_log();
    tick(NS'(1) << SRC_KEY_X, 1'b0);
    idle(2);
    tick(NS'(1) << SRC_HOLE, 1'b0);
    idle(20);
    check_seq("preempt_on", 0, '{4, 1});
    check("preempt_on_len", son_cnt[0], 3 + PC);
    check_seq("preempt_off", 1, '{4, 1});
    check("preempt_off_len", son_cnt[1], 2 * PC);

    // Retrigger of the playing source gives one replay
    clear_log();
    tick(NS'(1) << SRC_BALL, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) tick(NS'(1) << SRC_BALL, 1'b0);
    idle(20);
    check_seq("retrig", 0, '{2, 2});

    // Mute during PLAY
    clear_log();
    tick(NS'(1) << SRC_KEY_ENTER, 1'b0);
    idle(1);
    tick(NS'(1) << SRC_KEY_Y, 1'b1);
    check("mute_sound", son[0], 1'b0);
    tick('1, 1'b1);
    idle(12);
    check_seq("mute", 0, '{0});
    check("mute_pending", pnd[0], '0);

    // Reset while a tone is sounding
    clear_log();
    tick(NS'(1) << SRC_BORDER | NS'(1) << SRC_KEY_Y, 1'b0);
    idle(2);
    check("pre_reset_sound", son[0], 1'b1);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    check("reset_sound", son[0], 1'b0);
    check("reset_pending", pnd[0], '0);
    check("reset_busy", bsy[0], 1'b0);
    check("reset_tid", tid[0], '0);
    @(posedge clk); #1;
    resetN = 1'b1;
    clear_log();
    idle(10);
    check("post_reset_tones", q0.size(), 0);

    // Randomized traffic with occasional mute
    for (int i = 0; i < 800; i++) begin
      logic [NS-1:0] e;
      logic m;
      e = ($urandom_range(0, 5) == 0) ? NS'($urandom) : '0;
      m = ($urandom_range(0, 59) == 0);
      tick(e, m);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
